// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

    localparam int unsigned SERIAL_ADDER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath of serial_adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y ^ z;
    assign carry = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder driving one full_adder cell LSB-first, with valid/ready on both sides.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_y;
    logic             fa_sum;
    logic             fa_carry;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;

    // Subtraction is a + ~b + 1: invert each b bit and seed the carry with 1.
    assign fa_y = b_q[0] ^ sub_q;
`else
    assign fa_y = b_q[0];
`endif

    full_adder u_cell (
        .x     (a_q[0]),
        .y     (fa_y),
        .z     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift then overwrite the MSB so WIDTH=1 needs no special case.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_sum;
                carry_d          = fa_carry;
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_i;
    logic       sub1;
`endif

    logic       v1;
    logic       in_ready1;
    logic       a1;
    logic       b1;
    logic       c1;
    logic       out_valid1;
    logic       r1;
    logic       sum1;
    logic       cout1;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (c1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (r1),
        .sum       (sum1),
        .cout      (cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the WIDTH=8 instance including latency checks.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tc, input logic ts, input logic [7:0] es, input logic ec);
        a        = ta;
        b        = tb_v;
        cin      = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i    = ts;
`else
        if (ts) $display("note: subtract step skipped in this build");
`endif
        in_valid = 1'b1;
        check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "/in_ready_run"}, 32'(in_ready), 32'd0);
        for (int i = 1; i < 8; i++) tick();
        check({tag, "/out_valid_early"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "/out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "/sum"}, 32'(sum), 32'(es));
        check({tag, "/cout"}, 32'(cout), 32'(ec));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/out_valid_taken"}, 32'(out_valid), 32'd0);
        check({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2:0] combo;
        logic [1:0] exp1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        v1        = 1'b0;
        a1        = 1'b0;
        b1        = 1'b0;
        c1        = 1'b0;
        r1        = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i     = 1'b0;
        sub1      = 1'b0;
`endif

        #12;
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/sum", 32'(sum), 32'd0);
        check("reset/cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();

        op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
        op8("wrap_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1);

        // Stall in DONE with a competing request held on the input side.
        a        = 8'h12;
        b        = 8'h34;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("stall/out_valid", 32'(out_valid), 32'd1);
        a        = 8'hAA;
        b        = 8'hAA;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall/sum", 32'(sum), 32'h46);
            check("stall/cout", 32'(cout), 32'd0);
            check("stall/in_ready", 32'(in_ready), 32'd0);
            check("stall/out_valid_held", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall/taken", 32'(out_valid), 32'd0);
        check("stall/in_ready_back", 32'(in_ready), 32'd1);

        // Asynchronous reset during the third RUN cycle.
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/sum", 32'(sum), 32'd0);
        check("abort/in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        op8("after_abort_03_04", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);

        // WIDTH=1 sweep of the full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            a1    = combo[2];
            b1    = combo[1];
            c1    = combo[0];
            exp1  = 2'(a1) + 2'(b1) + 2'(c1);
            v1    = 1'b1;
            check("w1/in_ready", 32'(in_ready1), 32'd1);
            tick();
            v1 = 1'b0;
            check("w1/out_valid_early", 32'(out_valid1), 32'd0);
            tick();
            check("w1/out_valid", 32'(out_valid1), 32'd1);
            check("w1/sum", 32'(sum1), 32'(exp1[0]));
            check("w1/cout", 32'(cout1), 32'(exp1[1]));
            r1 = 1'b1;
            tick();
            r1 = 1'b0;
        end

`ifdef SERIAL_ADDER_SUB_EN
        op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        op8("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
        op8("nosub_07_05", 8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that sits directly upstream of the `full_adder` cell and drives it one bit per clock. It accepts two operands and a carry-in through a valid/ready handshake and shifts them LSB-first through a single `full_adder` instance. A registered carry closes the loop between bits. It returns the N-bit sum plus carry-out through a second valid/ready handshake, trading latency for a single-cell datapath.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range ≥ 1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in.
- `sub`  in  1  subtract request; present only when `SERIAL_ADDER_SUB_EN` is defined.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result bits.
- `cout`  out  1  final carry-out.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `a`, `b` and the carry register into internal shift registers.
  - Carry register loads `cin`, or 1 when subtracting.
  - Clear the bit counter, then go to RUN.
- RUN:
  - Each cycle, feed the shift-register LSBs and the carry register into `full_adder` (x=a[0], y=b[0], z=carry).
  - Shift the result register right with the new sum bit entering at the MSB.
  - Update the carry register from the cell's `carry`.
  - Shift the operands right and increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - `out_valid`=1; `sum` holds the full result and `cout` the final carry.
  - Both stay stable until `out_valid && out_ready`, then go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag.
- `in_ready` is asserted only in IDLE; inputs presented in RUN or DONE are ignored.
- `out_ready` is ignored outside DONE.
- WIDTH=1: RUN lasts exactly one cycle.
- Bit counter width is $clog2(WIDTH+1).
- Counter and shift registers wrap or clear only on accept; there is no free-running behaviour.

## Timing
- Reset values, asserted asynchronously:
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `sum`=0, `cout`=0.
  - Carry, counter and shift registers cleared.
- Reset mid-RUN or in DONE aborts the operation; the result is discarded.
- Latency: if accept occurs at edge T, `out_valid` rises after edge T+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH RUN cycles, ≥1 DONE cycle, 1 IDLE cycle.
- Result is registered; no combinational path from `a`/`b` to `sum`/`cout`.
- `in_ready` depends only on state, never combinationally on `in_valid` or `out_ready`.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - Port `sub` exists and is captured on accept.
  - When `sub`=1, y=~b[0] every bit, the carry register is initialised to 1 and `cin` is ignored.
  - Result is a − b with `cout` = NOT borrow.
  - When `sub`=0, behaviour matches the undefined case.
- `SERIAL_ADDER_SUB_EN` undefined: no `sub` port; pure addition.

## Structure
- Package `serial_adder_pkg` holds:
  - FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH constant.
- One sub-module: the existing `full_adder` (ports x, y, z, sum, carry), instantiated exactly once as the bit cell.
- Control, counter and shift registers live in `serial_adder` itself.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0 → after 8 RUN cycles: `sum`=8'h10, `cout`=0, `out_valid` rising exactly 8 edges after accept.
- a=8'hFF, b=8'h01, cin=1 → `sum`=8'h01, `cout`=1 (wrap-around).
- Hold `out_ready`=0 for 5 cycles in DONE → `sum`/`cout` stable; `in_ready`=0 throughout; second `in_valid` ignored until result taken.
- Drive `rst_n`=0 in the 3rd RUN cycle → immediately `out_valid`=0, `sum`=0, `in_ready`=1; next operand pair a=8'h03, b=8'h04 yields 8'h07.
- WIDTH=1 build: exhaustive sweep of all 8 (a,b,cin) combinations → matches the full-adder truth table, 1-cycle RUN each.
- With `SERIAL_ADDER_SUB_EN`, a=8'h05, b=8'h07, sub=1 → `sum`=8'hFE, `cout`=0; a=8'h07, b=8'h05, sub=1 → `sum`=8'h02, `cout`=1.
